// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC stall control, imem request/ack handshake and the
// IF/ID valid/ready output register backed by a one-entry skid buffer.
module fetch_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  input  logic             redirect,
  output logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             decode_ready,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_count
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    KILL
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_i;
  logic [WIDTH-1:0] r_skid_pc;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [TW-1:0]    r_tmo;

  logic w_in_req;
  logic w_busy;
  logic w_free;
  logic w_take;
  logic w_park;
  logic w_drain;
  logic w_xfer;
  logic w_wait;

  assign w_in_req = (r_state == REQ);
  assign w_busy   = (r_state == REQ) || (r_state == KILL);
  assign w_free   = !r_valid || decode_ready;
  assign w_take   = w_in_req && imem_ack && !redirect && w_free;
  assign w_park   = w_in_req && imem_ack && !redirect && !w_free;
  assign w_drain  = (r_state == HOLD) && r_skid_v &&
                    decode_ready && !redirect;
  assign w_xfer   = r_valid && decode_ready;
  assign w_wait   = w_busy && !imem_ack && !redirect;

  // PC advances only when the fetched word has somewhere to go,
  // or when execute forces a new target.
  assign stall     = !(redirect || w_take || w_drain);
  assign imem_req  = w_in_req;
  assign imem_addr = w_in_req ? PCF : '0;

  assign instr_valid = r_valid;
  assign InstrD      = r_instr;
  assign PCD         = r_pc;
  assign fetch_err   = r_err;
  assign fetch_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_skid_v  <= 1'b0;
      r_skid_i  <= '0;
      r_skid_pc <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_tmo     <= '0;
    end else begin
      if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_wait) begin
        if (r_tmo != TMAX) begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else if ((w_busy && imem_ack) || redirect) begin
        r_tmo <= '0;
      end

      if (r_tmo == TMAX) begin
        r_err <= 1'b1;
      end

      if (redirect) begin
        r_valid  <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (w_take) begin
        r_valid <= 1'b1;
        r_instr <= imem_rdata;
        r_pc    <= PCF;
      end else if (w_park) begin
        r_skid_v  <= 1'b1;
        r_skid_i  <= imem_rdata;
        r_skid_pc <= PCF;
      end else if (w_drain) begin
        r_valid  <= 1'b1;
        r_instr  <= r_skid_i;
        r_pc     <= r_skid_pc;
        r_skid_v <= 1'b0;
      end else if (decode_ready) begin
        r_valid <= 1'b0;
      end

      // A redirect racing the cancelled ack in KILL still retires it.
      unique case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (redirect) begin
            r_state <= imem_ack ? REQ : KILL;
          end else if (w_park) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || decode_ready) begin
            r_state <= REQ;
          end
        end
        KILL: begin
          if (imem_ack) begin
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural PC, variable-latency memory
// and a sequential-stream scoreboard for the decode side.
module tb_fetch_sequencer;
  localparam int W  = 32;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  pc;
  logic          redirect = 1'b0;
  logic [W-1:0]  target = '0;
  logic          stall;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack;
  logic [W-1:0]  imem_rdata;
  logic          instr_valid;
  logic          decode_ready = 1'b0;
  logic [W-1:0]  InstrD;
  logic [W-1:0]  PCD;
  logic          fetch_err;
  logic [CW-1:0] fetch_count;

  int vec  = 0;
  int errs = 0;

  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_addr;
  int           m_lat  = 1;
  bit           m_rand = 1'b0;
  bit           m_go   = 1'b0;
  bit           f_ack  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory: takes one request when idle, acks it m_lat cycles later.
  assign imem_ack = f_ack || (m_busy && (m_cnt == 0 || m_go));
  assign imem_rdata = f_ack ? 32'hDEAD_BEEF :
                      (imem_ack ? mem_word(m_addr) : '0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0 || m_go) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end else if (imem_req) begin
      m_busy <= 1'b1;
      m_addr <= imem_addr;
      m_cnt  <= m_rand ? int'($urandom_range(0, 3)) : m_lat - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (redirect) pc <= target;
    else if (!stall) pc <= pc + 32'd4;
  end

  fetch_sequencer #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCF          (pc),
    .redirect     (redirect),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .InstrD       (InstrD),
    .PCD          (PCD),
    .fetch_err    (fetch_err),
    .fetch_count  (fetch_count)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; f_ack = 1'b0; m_go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL rst_stall got %b want 1", stall); end
    vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", imem_req); end
    vec++; if (imem_addr !== '0) begin errs++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    vec++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    vec++; if (InstrD !== '0) begin errs++; $display("FAIL rst_instr got %h want 0", InstrD); end
    vec++; if (PCD !== '0) begin errs++; $display("FAIL rst_pcd got %h want 0", PCD); end
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", fetch_err); end
    vec++; if (fetch_count !== '0) begin errs++; $display("FAIL rst_count got %0d want 0", fetch_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lat1();
    int n;
    n = 0;
    m_lat = 1; m_rand = 1'b0; decode_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk); #1;
      if (imem_ack) begin
        vec++; if (stall !== 1'b0) begin errs++; $display("FAIL lat1_ack_stall got %b want 0", stall); end
      end
      if (instr_valid && decode_ready) begin
        vec++; if (PCD !== 32'(n * 4)) begin errs++; $display("FAIL lat1_pcd got %h want %h", PCD, 32'(n * 4)); end
        vec++; if (InstrD !== mem_word(32'(n * 4))) begin errs++; $display("FAIL lat1_instr got %h want %h", InstrD, mem_word(32'(n * 4))); end
        n++;
      end
    end
    vec++; if (n != 4) begin errs++; $display("FAIL lat1_transfers got %0d want 4", n); end
    @(negedge clk); #1;
    vec++; if (fetch_count !== 16'd4) begin errs++; $display("FAIL lat1_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_lat3();
    int run, fetches, pulses;
    logic [W-1:0] held;
    bit holding, pv;
    run = 0; fetches = 0; pulses = 0; holding = 0; pv = 0; held = '0;
    m_lat = 3; m_rand = 1'b0; decode_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 80 && fetches < 5; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        vec++; if (pv || PCD !== 32'(pulses * 4)) begin errs++; $display("FAIL lat3_pulse got pcd %h prev %b want %h", PCD, pv, 32'(pulses * 4)); end
        pulses++;
      end
      pv = instr_valid;
      if (imem_req && !imem_ack) begin
        if (holding) begin
          vec++; if (imem_addr !== held) begin errs++; $display("FAIL lat3_addr_hold got %h want %h", imem_addr, held); end
        end
        held = imem_addr; holding = 1'b1;
      end
      if (stall) begin
        run++;
      end else begin
        if (fetches > 0) begin
          vec++; if (run != 3) begin errs++; $display("FAIL lat3_stall_run got %0d want 3", run); end
        end
        fetches++; run = 0; holding = 1'b0;
      end
    end
    vec++; if (fetches != 5) begin errs++; $display("FAIL lat3_fetches got %0d want 5", fetches); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] fi, fp;
    ok = 0;
    m_lat = 1; m_rand = 1'b0; decode_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin ok = 1; break; end
    end
    decode_ready = 1'b0;
    #1;
    fi = InstrD; fp = PCD;
    vec++; if (!ok || fp !== 32'h0) begin errs++; $display("FAIL bp_first got valid %b pcd %h want 1 0", ok, fp); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      vec++; if (!instr_valid || InstrD !== fi || PCD !== fp) begin errs++; $display("FAIL bp_out_stable got %b %h %h want 1 %h %h", instr_valid, InstrD, PCD, fi, fp); end
      if (k >= 1) begin
        vec++; if (stall !== 1'b1) begin errs++; $display("FAIL bp_stall k%0d got %b want 1", k, stall); end
      end
      if (k >= 2) begin
        vec++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_hold_req k%0d got %b want 0", k, imem_req); end
      end
    end
    @(negedge clk);
    decode_ready = 1'b1;
    #1;
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL bp_release_stall got %b want 0", stall); end
    @(negedge clk); #1;
    vec++; if (!instr_valid || PCD !== 32'h4 || InstrD !== mem_word(32'h4)) begin errs++; $display("FAIL bp_skid_out got %b %h %h want 1 4 %h", instr_valid, PCD, InstrD, mem_word(32'h4)); end
    vec++; if (pc !== 32'h8) begin errs++; $display("FAIL bp_pc_once got %h want 8", pc); end
    vec++; if (fetch_count !== 16'd1) begin errs++; $display("FAIL bp_count got %0d want 1", fetch_count); end
  endtask

  task automatic test_redirect_kill();
    bit seen, got;
    seen = 0; got = 0;
    m_lat = 4; m_rand = 1'b0; decode_ready = 1'b1;
    do_reset();
    redirect = 1'b1; target = 32'h10;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errs++; $display("FAIL kill_req10 got %b %h want 1 10", imem_req, imem_addr); end
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; target = 32'h100;
    #1;
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL kill_redir_stall got %b want 0", stall); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    vec++; if (imem_req !== 1'b0 || stall !== 1'b1) begin errs++; $display("FAIL kill_state got req %b stall %b want 0 1", imem_req, stall); end
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        got = 1;
        vec++; if (PCD !== 32'h100 || InstrD !== mem_word(32'h100)) begin errs++; $display("FAIL kill_first_out got %h %h want 100 %h", PCD, InstrD, mem_word(32'h100)); end
      end else if (imem_req && !seen) begin
        seen = 1;
        vec++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL kill_next_addr got %h want 100", imem_addr); end
      end
    end
    vec++; if (!seen || !got) begin errs++; $display("FAIL kill_progress got req %b valid %b want 1 1", seen, got); end
  endtask

  task automatic test_redirect_ack();
    bit hit, got;
    hit = 0; got = 0;
    m_lat = 2; m_rand = 1'b0; decode_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (imem_ack) begin hit = 1; break; end
    end
    redirect = 1'b1; target = 32'h200;
    #1;
    vec++; if (!hit || stall !== 1'b0) begin errs++; $display("FAIL rack_stall got ack %b stall %b want 1 0", hit, stall); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    vec++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rack_dropped got %b want 0", instr_valid); end
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errs++; $display("FAIL rack_next got %b %h want 1 200", imem_req, imem_addr); end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        got = 1;
        vec++; if (PCD !== 32'h200) begin errs++; $display("FAIL rack_first_out got %h want 200", PCD); end
      end
    end
    vec++; if (!got) begin errs++; $display("FAIL rack_no_output got 0 want 1"); end
  endtask

  task automatic test_timeout();
    m_lat = 100000; m_rand = 1'b0; decode_ready = 1'b1;
    do_reset();
    repeat (TO - 4) @(negedge clk);
    #1;
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL tmo_early got %b want 0", fetch_err); end
    repeat (10) @(negedge clk);
    #1;
    vec++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL tmo_set got %b want 1", fetch_err); end
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errs++; $display("FAIL tmo_waiting got %b %h want 1 0", imem_req, imem_addr); end
    m_go = 1'b1;
    @(negedge clk);
    m_go = 1'b0;
    #1;
    vec++; if (instr_valid !== 1'b1 || fetch_err !== 1'b1) begin errs++; $display("FAIL tmo_sticky got valid %b err %b want 1 1", instr_valid, fetch_err); end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vec++; if (stall !== 1'b1 || imem_req !== 1'b0 || imem_addr !== '0) begin errs++; $display("FAIL tmo_rst_ctl got %b %b %h want 1 0 0", stall, imem_req, imem_addr); end
    vec++; if (instr_valid !== 1'b0 || InstrD !== '0 || PCD !== '0) begin errs++; $display("FAIL tmo_rst_out got %b %h %h want 0 0 0", instr_valid, InstrD, PCD); end
    vec++; if (fetch_err !== 1'b0 || fetch_count !== '0) begin errs++; $display("FAIL tmo_rst_err got %b %0d want 0 0", fetch_err, fetch_count); end
    @(negedge clk);
    rst = 1'b0; f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    #1;
    vec++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== '0) begin errs++; $display("FAIL tmo_orphan got %b %b %h want 0 1 0", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_pc, p_pc, p_i;
    bit p_redir, p_valid, p_ready;
    int n;
    exp_pc = '0; p_pc = '0; p_i = '0;
    p_redir = 0; p_valid = 0; p_ready = 0; n = 0;
    m_rand = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      decode_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      target = 32'($urandom_range(0, 1023)) << 2;
      #1;
      if (imem_req) begin
        vec++; if (imem_addr !== pc) begin errs++; $display("FAIL rnd_addr c%0d got %h want %h", c, imem_addr, pc); end
      end
      vec++; if (fetch_count !== CW'(n)) begin errs++; $display("FAIL rnd_count c%0d got %0d want %0d", c, fetch_count, CW'(n)); end
      if (p_redir) begin
        vec++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL rnd_flush c%0d got %b want 0", c, instr_valid); end
      end else if (p_valid && !p_ready) begin
        vec++; if (!instr_valid || PCD !== p_pc || InstrD !== p_i) begin errs++; $display("FAIL rnd_stable c%0d got %b %h %h want 1 %h %h", c, instr_valid, PCD, InstrD, p_pc, p_i); end
      end
      if (redirect) begin
        vec++; if (stall !== 1'b0) begin errs++; $display("FAIL rnd_redir_stall c%0d got %b want 0", c, stall); end
      end
      if (instr_valid && decode_ready) begin
        vec++; if (PCD !== exp_pc || InstrD !== mem_word(exp_pc)) begin errs++; $display("FAIL rnd_stream c%0d got %h %h want %h %h", c, PCD, InstrD, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      if (redirect) exp_pc = target;
      p_redir = redirect; p_valid = instr_valid; p_ready = decode_ready;
      p_pc = PCD; p_i = InstrD;
    end
    redirect = 1'b0;
    vec++; if (n < 300) begin errs++; $display("FAIL rnd_throughput got %0d want >=300", n); end
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL rnd_err got %b want 0", fetch_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lat1();
    test_lat3();
    test_backpressure();
    test_redirect_kill();
    test_redirect_ack();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
